soc_event_bus_tx: RTL and testbench
===================================

// Module: soc_event_bus_tx
// PURPOSE
//  Multi-channel SoC-to-cluster event-bus transmitter: write side of the token-based event FIFO.
//  Counts event pulses from NB_CH sources in per-channel saturating counters.
//  Round-robin arbitrates among them; pushes one event code per cycle into a DEPTH-entry buffer.
//  Publishes a Gray write token and tracks a Gray read pointer returned by the cluster-side consumer.
// PARAMETERS
//  NB_CH       4  number of event source channels (1..16)
//  EVNT_WIDTH  8  event code width; code for channel k = EVT_BASE + k
//  EVT_BASE    0  event code of channel 0
//  DEPTH       8  buffer entries; power of 2, >=2; AW = log2(DEPTH)
//  CNT_WIDTH   4  per-channel pending counter width
//  SYNC_STAGES 2  synchronizer flops on rp_i (>=2)
// PORTS
//  clk_i       in   1               clock
//  rst_i       in   1               synchronous reset, active-high
//  en_i        in   1               1 = pushes allowed; 0 = counting continues, no push
//  evt_i       in   NB_CH           per-channel single-cycle event pulse
//  evt_ack_o   out  NB_CH           one-cycle pulse: one event of channel k entered the buffer
//  ovf_o       out  NB_CH           sticky: pulse lost on saturated counter
//  ovf_clr_i   in   1               clears all ovf_o bits
//  wt_o        out  AW+1            Gray write pointer (write token)
//  rp_i        in   AW+1            Gray read pointer from consumer domain
//  da_o        out  DEPTH*EVNT_WIDTH  buffer contents, entry i at [i*EVNT_WIDTH +: EVNT_WIDTH]
//  full_o      out  1               buffer full vs synchronized rp
//  level_o     out  AW+1            occupied entries vs synchronized rp
// BEHAVIOUR
//  Reset (rst_i=1 at an edge): counters, wt_o, write pointer, buffer, da_o, sync flops := 0.
//    evt_ack_o, ovf_o, full_o, level_o := 0. Reset mid-operation discards all pending counts.
//  Counter k, per edge:
//    inc = evt_i[k]; dec = grant[k].
//    inc&dec -> unchanged; inc only -> +1, or stays at 2^CNT_WIDTH-1 with ovf_o[k] set to 1.
//    dec only -> -1.
//  ovf_clr_i clears ovf_o; a same-cycle saturation wins (bit stays 1).
//  rp_sync = rp_i after SYNC_STAGES flops; rp_bin = gray2bin(rp_sync).
//  wr_bin is the binary write pointer, AW+1 bits, wraps modulo 2*DEPTH; wt_o = bin2gray(wr_bin), registered.
//  full  = (wt_o == {~rp_sync[AW:AW-1], rp_sync[AW-2:0]}) (for AW=1: MSB inverted only).
//  level = wr_bin - rp_bin (mod 2^(AW+1)). full_o and level_o are registered from these (1 cycle late).
//  push = en_i & ~full & (any counter != 0). Combinational from current registered state.
//  Arbiter: round-robin over channels with counter != 0, starting at prio pointer (reset 0).
//    On grant to k: prio := (k+1) mod NB_CH. No push -> prio unchanged.
//  On push edge: buf[wr_bin[AW-1:0]] := EVT_BASE+k; wr_bin += 1; evt_ack_o[k] := 1 (else 0).
//  Latency: evt_i pulse at edge t -> counter at t -> earliest push edge t+1.
//    wt_o/da_o/evt_ack_o change at edge t+1.
//  Max throughput: 1 event/cycle. Entries not yet consumed are never overwritten (full blocks push).
//  Simultaneous events on all channels in one cycle are all counted; they drain over NB_CH pushes.
//  A pulse on the currently granted channel with a decrement is net zero. No event is lost below saturation.
// TESTING
//  T1 reset: drive evt_i=all 1 with rst_i=1 for 3 cycles.
//    -> wt_o=0, da_o=0, evt_ack_o=0, ovf_o=0, level_o=0 after release.
//  T2 single: evt_i[2] pulse, rp_i=0, EVT_BASE=0x10.
//    -> next edge da_o entry0=0x12, wt_o=1, evt_ack_o=4'b0100 for one cycle.
//  T3 round-robin: evt_i=4'b1111 in one cycle.
//    -> pushes codes 0x10,0x11,0x12,0x13 on 4 consecutive edges; wt_o Gray 1,3,2,6.
//  T4 full: rp_i held 0, 10 pulses on ch0 (DEPTH=8).
//    -> wt_o stops at gray(8)=0xC, full_o=1, counter=2.
//    -> rp_i stepped to gray(2): 2 more pushes after SYNC_STAGES+1 cycles.
//  T5 saturation: en_i=0, 17 pulses on ch1 (CNT_WIDTH=4).
//    -> counter=15, ovf_o[1]=1.
//    -> ovf_clr_i pulse with no new event clears it; same-cycle pulse keeps it 1.
//  T6 wrap: stream 40 events with rp_i tracking wt_o after 2-cycle lag.
//    -> pointer wraps mod 16, no lost or duplicated codes.
//    -> level_o never exceeds 8.

Source files
------------

// File: rtl/soc_event_bus_tx.sv
// soc_event_bus_tx: write side of a token-based SoC-to-cluster event FIFO.
// Per-channel pending counters feed a round-robin push into a DEPTH-entry buffer tracked by Gray pointers.
module soc_event_bus_tx #(
   parameter int NB_CH       = 4,
   parameter int EVNT_WIDTH  = 8,
   parameter int EVT_BASE    = 0,
   parameter int DEPTH       = 8,
   parameter int CNT_WIDTH   = 4,
   parameter int SYNC_STAGES = 2,
   localparam int AW         = $clog2(DEPTH)
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        en_i,
   input  logic [NB_CH-1:0]            evt_i,
   output logic [NB_CH-1:0]            evt_ack_o,
   output logic [NB_CH-1:0]            ovf_o,
   input  logic                        ovf_clr_i,
   output logic [AW:0]                 wt_o,
   input  logic [AW:0]                 rp_i,
   output logic [DEPTH*EVNT_WIDTH-1:0] da_o,
   output logic                        full_o,
   output logic [AW:0]                 level_o
);

   localparam int                   PW        = (NB_CH > 1) ? $clog2(NB_CH) : 1;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};
   localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
   localparam logic [AW:0]          PTR_ONE   = (AW+1)'(1);
   localparam logic [PW-1:0]        PRIO_ONE  = PW'(1);
   localparam logic [PW-1:0]        PRIO_LAST = PW'(NB_CH - 1);
   // Full when the write token equals the read token with its two top bits inverted.
   localparam logic [AW:0]          FULL_MASK = (AW >= 2) ? ((AW+1)'(3) << (AW-1)) : ((AW+1)'(1) << AW);

   function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
      logic [AW:0] b;
      b = g;
      for (int s = 1; s <= AW; s++) b = b ^ (g >> s);
      return b;
   endfunction

   logic [CNT_WIDTH-1:0]  cnt_r [NB_CH];
   logic [EVNT_WIDTH-1:0] buf_r [DEPTH];
   logic [AW:0]           rp_sync_r [SYNC_STAGES];
   logic [NB_CH-1:0]      ovf_r, ack_r, nz_s, grant_s, sat_s;
   logic [PW-1:0]         prio_r, grant_idx_s, prio_nxt_s;
   logic [AW:0]           wr_bin_r, wt_r, rp_sync_s, rp_bin_s, level_s, level_r;
   logic [EVNT_WIDTH-1:0] code_s;
   logic                  found_s, push_s, full_s, full_r;
   int                    cand_s;

   // Channels with pending events
   always_comb begin
      nz_s = '0;
      for (int k = 0; k < NB_CH; k++) nz_s[k] = (cnt_r[k] != '0);
   end

   // Occupancy against the synchronized read token
   always_comb begin
      rp_sync_s = rp_sync_r[SYNC_STAGES-1];
      rp_bin_s  = gray2bin(rp_sync_s);
      full_s    = (wt_r == (rp_sync_s ^ FULL_MASK));
      level_s   = wr_bin_r - rp_bin_s;
   end

   // Round-robin search starting at the priority pointer
   always_comb begin
      found_s     = 1'b0;
      grant_idx_s = '0;
      cand_s      = 0;
      for (int i = 0; i < NB_CH; i++) begin
         cand_s = ((int'(prio_r) + i) >= NB_CH) ? (int'(prio_r) + i - NB_CH) : (int'(prio_r) + i);
         if (!found_s && nz_s[cand_s[PW-1:0]]) begin
            found_s     = 1'b1;
            grant_idx_s = cand_s[PW-1:0];
         end else begin
            grant_idx_s = grant_idx_s;
         end
      end
      push_s     = en_i & ~full_s & found_s;
      grant_s    = push_s ? (NB_CH'(1) << grant_idx_s) : '0;
      prio_nxt_s = (grant_idx_s == PRIO_LAST) ? '0 : (grant_idx_s + PRIO_ONE);
      code_s     = EVNT_WIDTH'(EVT_BASE) + EVNT_WIDTH'(grant_idx_s);
   end

   // Pulses lost on a saturated counter that is not being drained this cycle
   always_comb begin
      sat_s = '0;
      for (int k = 0; k < NB_CH; k++) sat_s[k] = evt_i[k] & ~grant_s[k] & (cnt_r[k] == CNT_MAX);
   end

   // Pending counters and sticky overflow flags
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int k = 0; k < NB_CH; k++) cnt_r[k] <= '0;
         ovf_r <= '0;
      end else begin
         for (int k = 0; k < NB_CH; k++) begin
            case ({evt_i[k], grant_s[k]})
               2'b10:   cnt_r[k] <= (cnt_r[k] == CNT_MAX) ? cnt_r[k] : (cnt_r[k] + CNT_ONE);
               2'b01:   cnt_r[k] <= cnt_r[k] - CNT_ONE;
               default: cnt_r[k] <= cnt_r[k];
            endcase
         end
         ovf_r <= sat_s | (ovf_r & ~{NB_CH{ovf_clr_i}});
      end
   end

   // Buffer write, write pointer, Gray token and arbiter priority
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) buf_r[i] <= '0;
         wr_bin_r <= '0;
         wt_r     <= '0;
         prio_r   <= '0;
         ack_r    <= '0;
      end else begin
         ack_r <= grant_s;
         if (push_s) begin
            buf_r[wr_bin_r[AW-1:0]] <= code_s;
            wr_bin_r                <= wr_bin_r + PTR_ONE;
            wt_r                    <= bin2gray(wr_bin_r + PTR_ONE);
            prio_r                  <= prio_nxt_s;
         end else begin
            wr_bin_r <= wr_bin_r;
            wt_r     <= wt_r;
            prio_r   <= prio_r;
         end
      end
   end

   // Read token synchronizer and registered status
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < SYNC_STAGES; i++) rp_sync_r[i] <= '0;
         full_r  <= 1'b0;
         level_r <= '0;
      end else begin
         rp_sync_r[0] <= rp_i;
         for (int i = 1; i < SYNC_STAGES; i++) rp_sync_r[i] <= rp_sync_r[i-1];
         full_r  <= full_s;
         level_r <= level_s;
      end
   end

   // Flatten buffer onto the data bus
   always_comb begin
      da_o = '0;
      for (int i = 0; i < DEPTH; i++) da_o[i*EVNT_WIDTH +: EVNT_WIDTH] = buf_r[i];
   end

   assign evt_ack_o = ack_r;
   assign ovf_o     = ovf_r;
   assign wt_o      = wt_r;
   assign full_o    = full_r;
   assign level_o   = level_r;

endmodule

// File: tb/tb_soc_event_bus_tx.sv
// Bench for soc_event_bus_tx: directed scenarios plus random traffic against an
// occupancy/count-based reference model.
module tb_soc_event_bus_tx;
   localparam int NB_CH = 4, EVNT_WIDTH = 8, EVT_BASE = 16, DEPTH = 8, CNT_WIDTH = 4, SYNC_STAGES = 2;
   localparam int CMAX = 15;

   logic        clk = 1'b0;
   logic        rst, en, ovf_clr, full;
   logic [3:0]  evt, evt_ack, ovf, wt, rp, level;
   logic [63:0] da;

   soc_event_bus_tx #(.NB_CH(NB_CH), .EVNT_WIDTH(EVNT_WIDTH), .EVT_BASE(EVT_BASE), .DEPTH(DEPTH),
                      .CNT_WIDTH(CNT_WIDTH), .SYNC_STAGES(SYNC_STAGES)) dut (
      .clk_i(clk), .rst_i(rst), .en_i(en), .evt_i(evt), .evt_ack_o(evt_ack), .ovf_o(ovf),
      .ovf_clr_i(ovf_clr), .wt_o(wt), .rp_i(rp), .da_o(da), .full_o(full), .level_o(level));

   always #5 clk = ~clk;

   int total = 0, bad = 0;
   // reference model state
   int m_cnt[NB_CH];
   bit m_ovf[NB_CH];
   int m_buf[DEPTH];
   int m_sync[SYNC_STAGES];
   int m_prio, m_wr, m_ack_ch, m_level;
   bit m_full;
   // bench bookkeeping
   int inj[NB_CH], acks[NB_CH];
   int cons_mode, rd_total, lag1, lag2, lvl_max;

   function automatic int gray(input int b);
      return b ^ (b >> 1);
   endfunction

   function automatic int ungray(input int g);
      int b = g;
      for (int s = g >> 1; s != 0; s = s >> 1) b = b ^ s;
      return b;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      int rb, occ, k, c;
      bit any, inc, dec, sat;
      if (rst) begin
         for (int i = 0; i < NB_CH; i++) begin m_cnt[i] = 0; m_ovf[i] = 0; end
         for (int i = 0; i < DEPTH; i++) m_buf[i] = 0;
         for (int i = 0; i < SYNC_STAGES; i++) m_sync[i] = 0;
         m_prio = 0; m_wr = 0; m_ack_ch = -1; m_level = 0; m_full = 0;
         return;
      end
      rb  = ungray(m_sync[SYNC_STAGES-1]);
      occ = ((m_wr % 16) - rb + 16) % 16;
      any = 0;
      for (int i = 0; i < NB_CH; i++) if (m_cnt[i] > 0) any = 1;
      k = -1;
      if (en && occ != DEPTH && any)
         for (int i = 0; i < NB_CH; i++) begin
            c = (m_prio + i) % NB_CH;
            if (k < 0 && m_cnt[c] > 0) k = c;
         end
      for (int ch = 0; ch < NB_CH; ch++) begin
         inc = evt[ch];
         dec = (ch == k);
         sat = inc && !dec && m_cnt[ch] == CMAX;
         if (inc && !dec && !sat) m_cnt[ch]++;
         if (dec && !inc) m_cnt[ch]--;
         if (sat) m_ovf[ch] = 1;
         else if (ovf_clr) m_ovf[ch] = 0;
      end
      if (k >= 0) begin
         m_buf[m_wr % DEPTH] = EVT_BASE + k;
         m_wr   = m_wr + 1;
         m_prio = (k + 1) % NB_CH;
      end
      m_ack_ch = k;
      m_full   = (occ == DEPTH);
      m_level  = occ;
      for (int i = SYNC_STAGES - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
      m_sync[0] = int'(rp);
   endtask

   task automatic check_all();
      logic [63:0] exp_da;
      logic [3:0]  exp_ovf;
      exp_da = '0;
      exp_ovf = '0;
      for (int i = 0; i < DEPTH; i++) exp_da[i*8 +: 8] = 8'(m_buf[i]);
      for (int i = 0; i < NB_CH; i++) exp_ovf[i] = m_ovf[i];
      chk("wt", 64'(wt), 64'(gray(m_wr % 16)));
      chk("da", da, exp_da);
      chk("ack", 64'(evt_ack), (m_ack_ch >= 0) ? 64'(1 << m_ack_ch) : 64'(0));
      chk("ovf", 64'(ovf), 64'(exp_ovf));
      chk("full", 64'(full), 64'(m_full));
      chk("level", 64'(level), 64'(m_level));
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      check_all();
      for (int ch = 0; ch < NB_CH; ch++) if (evt_ack[ch]) acks[ch]++;
      if (int'(level) > lvl_max) lvl_max = int'(level);
      // consumer: follows the write count with a two-cycle lag (mode 1) or randomly (mode 2)
      lag2 = lag1;
      lag1 = m_wr;
      if (cons_mode == 1) rd_total = lag2;
      else if (cons_mode == 2 && rd_total < lag2 && $urandom_range(1, 0) == 1) rd_total++;
      if (cons_mode != 0) rp = 4'(gray(rd_total % 16));
   endtask

   task automatic do_reset();
      rst = 1'b1; evt = '0; ovf_clr = 1'b0; rp = '0;
      cons_mode = 0; rd_total = 0; lag1 = 0; lag2 = 0;
      cycle();
      cycle();
      rst = 1'b0;
   endtask

   logic [7:0] t3_code[4];
   logic [3:0] t3_gray[4];
   int         sum;

   initial begin
      t3_code = '{8'h10, 8'h11, 8'h12, 8'h13};
      t3_gray = '{4'd1, 4'd3, 4'd2, 4'd6};
      for (int i = 0; i < NB_CH; i++) begin inj[i] = 0; acks[i] = 0; end
      cons_mode = 0; rd_total = 0; lag1 = 0; lag2 = 0; lvl_max = 0;
      rst = 1'b1; en = 1'b1; ovf_clr = 1'b0; rp = '0; evt = 4'hF;

      // T1 reset with all events asserted
      for (int i = 0; i < 3; i++) cycle();
      rst = 1'b0; evt = '0;
      cycle();
      chk("t1_wt", 64'(wt), 64'(0));
      chk("t1_da", da, 64'(0));
      chk("t1_ack", 64'(evt_ack), 64'(0));
      chk("t1_ovf", 64'(ovf), 64'(0));
      chk("t1_level", 64'(level), 64'(0));

      // T2 single event on channel 2
      evt = 4'b0100;
      cycle();
      evt = '0;
      cycle();
      chk("t2_da0", 64'(da[7:0]), 64'(8'h12));
      chk("t2_wt", 64'(wt), 64'(1));
      chk("t2_ack", 64'(evt_ack), 64'(4'b0100));
      cycle();
      chk("t2_ack_off", 64'(evt_ack), 64'(0));

      // T3 all channels at once drain in round-robin order
      do_reset();
      evt = 4'hF;
      cycle();
      evt = '0;
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("t3_code", 64'(da[i*8 +: 8]), 64'(t3_code[i]));
         chk("t3_wt", 64'(wt), 64'(t3_gray[i]));
      end

      // T4 full with rp held at 0, then release two entries
      do_reset();
      evt = 4'b0001;
      for (int i = 0; i < 10; i++) cycle();
      evt = '0;
      for (int i = 0; i < 6; i++) cycle();
      chk("t4_wt_full", 64'(wt), 64'(4'hC));
      chk("t4_full", 64'(full), 64'(1));
      rp = 4'(gray(2));
      cycle();
      cycle();
      chk("t4_wt_hold", 64'(wt), 64'(4'hC));
      cycle();
      chk("t4_wt_9", 64'(wt), 64'(4'hD));
      cycle();
      chk("t4_wt_10", 64'(wt), 64'(4'hF));
      for (int i = 0; i < 3; i++) cycle();
      chk("t4_wt_stop", 64'(wt), 64'(4'hF));
      chk("t4_full_again", 64'(full), 64'(1));

      // T5 saturation and overflow clear
      do_reset();
      en = 1'b0;
      evt = 4'b0010;
      for (int i = 0; i < 17; i++) cycle();
      evt = '0;
      cycle();
      chk("t5_ovf_set", 64'(ovf), 64'(4'b0010));
      ovf_clr = 1'b1;
      cycle();
      ovf_clr = 1'b0;
      chk("t5_ovf_clr", 64'(ovf), 64'(0));
      evt = 4'b0010; ovf_clr = 1'b1;
      cycle();
      evt = '0; ovf_clr = 1'b0;
      chk("t5_ovf_win", 64'(ovf), 64'(4'b0010));
      for (int i = 0; i < NB_CH; i++) acks[i] = 0;
      cons_mode = 1; en = 1'b1;
      for (int i = 0; i < 40; i++) cycle();
      chk("t5_drain", 64'(acks[1]), 64'(CMAX));

      // T6 random stream of 40 events with wrapping pointers
      do_reset();
      en = 1'b1; cons_mode = 1; lvl_max = 0;
      for (int i = 0; i < NB_CH; i++) begin inj[i] = 0; acks[i] = 0; end
      for (int n = 0; n < 40; n++) begin
         int ch;
         ch = int'($urandom_range(NB_CH - 1, 0));
         evt = 4'(1 << ch);
         inj[ch]++;
         cycle();
      end
      evt = '0;
      for (int i = 0; i < 30; i++) cycle();
      sum = 0;
      for (int ch = 0; ch < NB_CH; ch++) begin
         chk("t6_acks", 64'(acks[ch]), 64'(inj[ch]));
         sum += acks[ch];
      end
      chk("t6_total", 64'(sum), 64'(40));
      chk("t6_level_max", 64'(lvl_max <= DEPTH), 64'(1));

      // T7 random traffic with random enable, clears and a lagging consumer
      do_reset();
      cons_mode = 2;
      for (int n = 0; n < 400; n++) begin
         evt     = 4'($urandom);
         en      = ($urandom_range(3, 0) != 0);
         ovf_clr = ($urandom_range(7, 0) == 0);
         cycle();
      end
      evt = '0; ovf_clr = 1'b0; en = 1'b1;
      for (int i = 0; i < 60; i++) cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
